timing_seq_gen: RTL and testbench
=================================

TIMING_SEQ_GEN -- requirements
Module: timing_seq_gen

Interface
REQ-001 SHALL have parameter PH_W, default 3, phase-counter width; cycle length N = 2^PH_W clocks, legal PH_W >= 2.
REQ-002 SHALL have parameter STRETCH_MAX, default 15, maximum stretch clocks per cycle, legal 1..255.
REQ-003 SHALL have port clock  input  1  single master clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cs_n  input  1  CPU chip select, active low.
REQ-006 SHALL have port rw  input  1  CPU direction, 1 = read, 0 = write.
REQ-007 SHALL have port hold  input  1  cycle-stretch request, active high.
REQ-008 SHALL have port phase  output  PH_W  current phase count, 0..N-1.
REQ-009 SHALL have port pe  output  1  E clock.
REQ-010 SHALL have port pq  output  1  Q clock, leads pe by N/4 clocks.
REQ-011 SHALL have port rden  output  1  VRAM read enable.
REQ-012 SHALL have port wren  output  1  VRAM write enable.
REQ-013 SHALL have port vlatch  output  1  video-data latch strobe.
REQ-014 SHALL have port stretch_to  output  1  stretch-timeout pulse.

Function
REQ-015 SHALL synchronise reset deassertion through two flops (res_sync); res_sync goes high on the 2nd rising clock edge after reset rises.
REQ-016 SHALL hold phase at 0 while res_sync is low, then increment phase by 1 per clock, wrapping N-1 -> 0.
REQ-017 SHALL drive every output from a flop, with no combinational path from inputs to outputs.
REQ-018 SHALL drive pe high exactly while phase is in N/2..N-1.
REQ-019 SHALL drive pq high exactly while phase is in N/4..3N/4-1.
REQ-020 SHALL sample cs_n and rw on the edge where phase becomes 0, capturing access type READ, WRITE or NONE for the whole cycle.
REQ-021 SHALL ignore changes on cs_n and rw between sample edges.
REQ-022 SHALL drive rden high exactly while access = READ and phase is in N/2..N-1.
REQ-023 SHALL drive wren high exactly while access = WRITE and phase is in N/2+1..N-2, leaving one guard clock at each end.
REQ-024 SHALL pulse vlatch high for one clock while phase = N/2-1, only when access = NONE.
REQ-025 SHALL sample hold only while phase = N-1; with hold high, phase SHALL stay at N-1 (pe high, pq low, strobes frozen) and the stretch counter SHALL increment.
REQ-026 SHALL leave phase N-1 on the first clock where hold is low, or after STRETCH_MAX held clocks, whichever comes first.
REQ-027 SHALL, on a forced (timeout) exit, advance phase to 0 and pulse stretch_to high for exactly one clock.
REQ-028 SHALL clear the stretch counter whenever phase leaves N-1.
REQ-029 SHALL ignore hold at every phase other than N-1.
REQ-030 SHALL, when hold deasserts on the same edge the counter reaches STRETCH_MAX, treat the exit as normal, with stretch_to low.

Reset
REQ-031 SHALL, on reset low, asynchronously force phase=0, access=NONE, stretch counter=0 and res_sync=0.
REQ-032 SHALL, on reset low, asynchronously force pe, pq, rden, wren, vlatch and stretch_to to 0.
REQ-033 SHALL force the same reset state when reset is asserted mid-cycle or mid-stretch, and SHALL restart at phase 0 after resynchronisation.

Verification (N=8, STRETCH_MAX=15)
REQ-034 SHALL cover: reset released, cs_n=1 -> phase starts incrementing 1 clock after res_sync high; pq high phases 2-5; pe high 4-7; vlatch one-clock pulse at phase 3 every 8 clocks.
REQ-035 SHALL cover: cs_n=0, rw=1 held across the phase-0 edge -> rden high phases 4-7 of that cycle; wren=0; vlatch=0.
REQ-036 SHALL cover: cs_n=0, rw=0 at phase 0, then cs_n=1 at phase 2 -> wren high phases 5-6 only; rden=0.
REQ-037 SHALL cover: hold=1 for 5 clocks from phase 7 -> phase stays 7 for 5 extra clocks with pe=1, then wraps to 0; stretch_to=0.
REQ-038 SHALL cover: hold stuck at 1 -> phase 7 held 15 clocks, then wraps to 0 with a one-clock stretch_to pulse, and repeats each cycle.
REQ-039 SHALL cover: reset pulsed low at phase 5 during a read -> all outputs 0 immediately; normal sequence resumes from phase 0 after 2-clock resync.

Source files
------------

// File: rtl/timing_seq_gen.sv
// timing_seq_gen: CPU/video bus timing generator.
// A free-running phase counter (N = 2^PH_W clocks per cycle) produces the
// E/Q clock pair, VRAM read/write enables and a video latch strobe. A CPU
// access is captured once per cycle at phase 0. The cycle can be stretched
// at phase N-1 by 'hold', up to STRETCH_MAX clocks, after which a timeout
// pulse is raised. Every output is registered and derived from next-state.
module timing_seq_gen #(
  parameter int PH_W        = 3,
  parameter int STRETCH_MAX = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cs_n,
  input  logic            rw,
  input  logic            hold,
  output logic [PH_W-1:0] phase,
  output logic            pe,
  output logic            pq,
  output logic            rden,
  output logic            wren,
  output logic            vlatch,
  output logic            stretch_to
);

  localparam int N    = 2**PH_W;
  localparam int SC_W = $clog2(STRETCH_MAX + 1);

  localparam logic [PH_W-1:0] P_LAST = PH_W'(N - 1);
  localparam logic [PH_W-1:0] P_HALF = PH_W'(N / 2);
  localparam logic [PH_W-1:0] P_Q0   = PH_W'(N / 4);
  localparam logic [PH_W-1:0] P_Q1   = PH_W'(3 * N / 4 - 1);
  localparam logic [PH_W-1:0] P_W0   = PH_W'(N / 2 + 1);
  localparam logic [PH_W-1:0] P_W1   = PH_W'(N - 2);
  localparam logic [PH_W-1:0] P_VL   = PH_W'(N / 2 - 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STRETCH_MAX);

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_t;

  logic            sync1, res_sync;
  logic [PH_W-1:0] phase_nxt;
  acc_t            access, acc_nxt;
  logic [SC_W-1:0] scnt, scnt_nxt;
  logic            forced;
  logic            pe_d, pq_d, rden_d, wren_d, vlatch_d;

  // Two-flop synchroniser on reset release; assertion stays asynchronous.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      res_sync <= 1'b0;
    end else begin
      sync1    <= 1'b1;
      res_sync <= sync1;
    end
  end

  // State register: phase, captured access, stretch counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase  <= '0;
      access <= ACC_NONE;
      scnt   <= '0;
    end else begin
      phase  <= phase_nxt;
      access <= acc_nxt;
      scnt   <= scnt_nxt;
    end
  end

  // Next state: advance phase, stretch at the last phase, sample access at phase 0.
  always_comb begin
    phase_nxt = phase;
    scnt_nxt  = scnt;
    forced    = 1'b0;
    if (!res_sync) begin
      phase_nxt = '0;
      scnt_nxt  = '0;
    end else if (phase == P_LAST) begin
      if (hold && scnt != SC_MAX) begin
        scnt_nxt = scnt + SC_W'(1);
      end else begin
        // Still holding here means the counter ran out: timeout exit.
        phase_nxt = '0;
        scnt_nxt  = '0;
        forced    = hold;
      end
    end else begin
      phase_nxt = phase + PH_W'(1);
    end

    acc_nxt = access;
    if (phase_nxt == '0)
      acc_nxt = cs_n ? ACC_NONE : (rw ? ACC_READ : ACC_WRITE);
  end

  // Output decode from next state so the registered outputs line up with phase.
  always_comb begin
    pe_d     = (phase_nxt >= P_HALF);
    pq_d     = (phase_nxt >= P_Q0) && (phase_nxt <= P_Q1);
    rden_d   = (acc_nxt == ACC_READ) && pe_d;
    wren_d   = (acc_nxt == ACC_WRITE) && (phase_nxt >= P_W0) && (phase_nxt <= P_W1);
    vlatch_d = (acc_nxt == ACC_NONE) && (phase_nxt == P_VL);
  end

  // Output register: every output comes straight from a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pe         <= 1'b0;
      pq         <= 1'b0;
      rden       <= 1'b0;
      wren       <= 1'b0;
      vlatch     <= 1'b0;
      stretch_to <= 1'b0;
    end else begin
      pe         <= pe_d;
      pq         <= pq_d;
      rden       <= rden_d;
      wren       <= wren_d;
      vlatch     <= vlatch_d;
      stretch_to <= forced;
    end
  end

endmodule

// File: tb/tb_timing_seq_gen.sv
// Bench for timing_seq_gen: directed scenarios followed by random stimulus,
// all checked against a cycle-level reference model of the phase rules.
module tb_timing_seq_gen;

  localparam int PH_W = 3;
  localparam int SMAX = 15;
  localparam int N    = 2**PH_W;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            cs_n  = 1'b1;
  logic            rw    = 1'b1;
  logic            hold  = 1'b0;
  logic [PH_W-1:0] phase;
  logic            pe, pq, rden, wren, vlatch, stretch_to;

  int checks = 0;
  int errors = 0;

  // Reference model state: clocks since reset release, phase, access
  // (0 none, 1 read, 2 write), held clocks, timeout flag.
  int m_rs, m_ph, m_acc, m_held;
  bit m_sto;

  always #5 clock = ~clock;

  timing_seq_gen #(.PH_W(PH_W), .STRETCH_MAX(SMAX)) dut (
    .clock(clock), .reset(reset), .cs_n(cs_n), .rw(rw), .hold(hold),
    .phase(phase), .pe(pe), .pq(pq), .rden(rden), .wren(wren),
    .vlatch(vlatch), .stretch_to(stretch_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (phase model %0d)", tag, obs, exp, m_ph);
    end
  endtask

  task automatic model_reset();
    m_rs = 0; m_ph = 0; m_acc = 0; m_held = 0; m_sto = 0;
  endtask

  // One rising edge of the reference model, using inputs present at the edge.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    m_sto = 0;
    if (m_rs < 2) begin
      m_ph = 0; m_held = 0;
    end else if (m_ph == N - 1) begin
      if (hold && m_held < SMAX) m_held++;
      else begin
        m_sto = hold; m_ph = 0; m_held = 0;
      end
    end else begin
      m_ph++;
    end
    if (m_ph == 0) m_acc = cs_n ? 0 : (rw ? 1 : 2);
    if (m_rs < 2) m_rs++;
  endtask

  task automatic check_all();
    chk("phase",      phase,      m_ph);
    chk("pe",         pe,         (m_ph >= N/2));
    chk("pq",         pq,         (m_ph >= N/4 && m_ph < 3*N/4));
    chk("rden",       rden,       (m_acc == 1 && m_ph >= N/2));
    chk("wren",       wren,       (m_acc == 2 && m_ph >= N/2 + 1 && m_ph <= N - 2));
    chk("vlatch",     vlatch,     (m_acc == 0 && m_ph == N/2 - 1));
    chk("stretch_to", stretch_to, m_sto);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 64 && m_ph != p; i++) step();
  endtask

  initial begin
    model_reset();
    // Reset held: everything at zero.
    #1 check_all();
    repeat (3) step();
    #2 reset = 1'b1;

    // Idle cycles: resync, then E/Q and vlatch pulses.
    repeat (30) step();

    // Read captured at phase 0.
    run_to(N - 1);
    cs_n = 1'b0; rw = 1'b1;
    step();
    cs_n = 1'b1; rw = 1'b0;
    repeat (N) step();

    // Write, chip select dropped at phase 2 (ignored until next sample).
    run_to(N - 1);
    cs_n = 1'b0; rw = 1'b0;
    repeat (3) step();
    cs_n = 1'b1;
    repeat (N) step();

    // Short stretch: 5 held clocks, normal exit.
    run_to(N - 1);
    hold = 1'b1;
    repeat (5) step();
    hold = 1'b0;
    repeat (N + 2) step();

    // Hold stuck: repeated timeouts.
    hold = 1'b1;
    repeat (3 * (N + SMAX + 1)) step();
    hold = 1'b0;

    // Hold released on the edge the counter hits its limit: normal exit.
    run_to(N - 1);
    hold = 1'b1;
    repeat (SMAX) step();
    hold = 1'b0;
    repeat (3) step();

    // Reset mid-read at phase 5.
    run_to(N - 1);
    cs_n = 1'b0; rw = 1'b1;
    step();
    cs_n = 1'b1;
    run_to(5);
    reset = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) step();
    reset = 1'b1;
    repeat (2 * N + 4) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cs_n  = 1'($urandom_range(0, 1));
      rw    = 1'($urandom_range(0, 1));
      hold  = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1; hold = 1'b0;
    repeat (N) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
